// File: rtl/jtag_arb_pkg.sv
// Shared types and helpers for the multi-host JTAG port arbiter.
package jtag_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESET_SEQ,
        ST_OWNED,
        ST_DRAIN
    } arb_state_e;

    // Synchroniser reset value, packed as {tck, tms, tdi, trst_n, req}.
    localparam logic [4:0] SYNC_SAFE = 5'b01010;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/jtag_pin_sync.sv
// Multi-stage synchroniser for one host's JTAG pin bundle; resets to a
// state that looks like an idle, non-requesting host.
module jtag_pin_sync
    import jtag_arb_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    input  logic trst_n,
    input  logic req,
    output logic tck_sync,
    output logic tms_sync,
    output logic tdi_sync,
    output logic trst_n_sync,
    output logic req_sync
);

    logic [4:0] stage [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= SYNC_SAFE;
        end else begin
            stage[0] <= {tck, tms, tdi, trst_n, req};
            for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign {tck_sync, tms_sync, tdi_sync, trst_n_sync, req_sync} = stage[SYNC_STAGES-1];

endmodule

// File: rtl/jtag_port_arbiter.sv
// Round-robin arbiter sharing one TAP between several debug hosts; every
// hand-over is preceded by a self-timed TMS=1 burst that parks the TAP in TLR.
module jtag_port_arbiter
    import jtag_arb_pkg::*;
#(
    parameter int NUM_PORTS    = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 64,
    parameter int RESET_TCKS   = 5,
    parameter int TCK_HALF     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_PORTS-1:0]         port_req,
    input  logic [NUM_PORTS-1:0]         port_tck,
    input  logic [NUM_PORTS-1:0]         port_tms,
    input  logic [NUM_PORTS-1:0]         port_tdi,
    input  logic [NUM_PORTS-1:0]         port_trst_n,
    output logic [NUM_PORTS-1:0]         port_tdo,
    output logic [NUM_PORTS-1:0]         port_grant,
    output logic                         jtag_clk,
    output logic                         jtag_tms,
    output logic                         jtag_tdi,
    output logic                         jtag_rst_n,
    input  logic                         jtag_tdo,
    output logic [$clog2(NUM_PORTS)-1:0] active_port,
    output logic                         busy,
    output logic [15:0]                  switch_count
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int HW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
    localparam int CW = $clog2(RESET_TCKS);
    localparam logic [HW-1:0] HALF_LAST  = HW'(TCK_HALF - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(RESET_TCKS - 1);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_TIMEOUT);

    logic [NUM_PORTS-1:0] tck_s, tms_s, tdi_s, trst_n_s, req_s;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_sync
        jtag_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk        (clk),
            .rst_n      (rst_n),
            .tck        (port_tck[g]),
            .tms        (port_tms[g]),
            .tdi        (port_tdi[g]),
            .trst_n     (port_trst_n[g]),
            .req        (port_req[g]),
            .tck_sync   (tck_s[g]),
            .tms_sync   (tms_s[g]),
            .tdi_sync   (tdi_s[g]),
            .trst_n_sync(trst_n_s[g]),
            .req_sync   (req_s[g])
        );
    end

    arb_state_e    state, state_next;
    logic [PW-1:0] rr_ptr, pend, pend_next, winner, sel;
    logic [HW-1:0] half_cnt, half_next;
    logic [CW-1:0] pulse_cnt, pulse_next;
    logic [IW-1:0] idle_cnt;
    logic          found, any_req, other_req, owner_tck, owner_tck_d, burst_done;
    logic          burst_clk_next, clk_next, tms_next, tdi_next, rst_n_next;
    logic [NUM_PORTS-1:0] grant_next;
    int            j;

    // Round-robin search starts just after the last owner.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        j      = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (!found && req_s[j]) begin
                winner = PW'(j);
                found  = 1'b1;
            end
        end
    end

    assign any_req    = |req_s;
    assign other_req  = |(req_s & ~port_grant);
    assign owner_tck  = tck_s[active_port];
    assign burst_done = (state == ST_RESET_SEQ) && (half_cnt == HALF_LAST) &&
                        !jtag_clk && (pulse_cnt == PULSE_LAST);
    assign sel        = (state == ST_RESET_SEQ) ? pend : active_port;

    always_comb begin
        state_next = state;
        pend_next  = pend;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = ST_RESET_SEQ;
                    pend_next  = winner;
                end
            end
            ST_RESET_SEQ: begin
                if (burst_done) state_next = req_s[pend] ? ST_OWNED : ST_IDLE;
            end
            ST_OWNED: begin
                if (!req_s[active_port] || (other_req && idle_cnt == IDLE_MAX))
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!owner_tck) begin
                    if (any_req) begin
                        state_next = ST_RESET_SEQ;
                        pend_next  = winner;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Burst generator: the registered jtag_clk doubles as the current burst level.
    always_comb begin
        half_next      = '0;
        pulse_next     = '0;
        burst_clk_next = 1'b1;
        if (state == ST_RESET_SEQ) begin
            burst_clk_next = jtag_clk;
            half_next      = half_cnt + 1'b1;
            pulse_next     = pulse_cnt;
            if (half_cnt == HALF_LAST) begin
                half_next      = '0;
                burst_clk_next = ~jtag_clk;
                if (!jtag_clk) pulse_next = pulse_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        clk_next   = 1'b0;
        tms_next   = 1'b1;
        tdi_next   = 1'b0;
        rst_n_next = 1'b1;
        grant_next = '0;
        case (state_next)
            ST_RESET_SEQ: clk_next = burst_clk_next;
            ST_OWNED, ST_DRAIN: begin
                clk_next        = tck_s[sel];
                tms_next        = tms_s[sel];
                tdi_next        = tdi_s[sel];
                rst_n_next      = trst_n_s[sel];
                grant_next[sel] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= PW'(NUM_PORTS - 1);
            pend         <= '0;
            active_port  <= '0;
            half_cnt     <= '0;
            pulse_cnt    <= '0;
            idle_cnt     <= '0;
            owner_tck_d  <= 1'b0;
            busy         <= 1'b0;
            switch_count <= '0;
            port_grant   <= '0;
            port_tdo     <= '1;
            jtag_clk     <= 1'b0;
            jtag_tms     <= 1'b1;
            jtag_tdi     <= 1'b0;
            jtag_rst_n   <= 1'b1;
        end else begin
            state       <= state_next;
            pend        <= pend_next;
            half_cnt    <= half_next;
            pulse_cnt   <= pulse_next;
            busy        <= (state_next != ST_IDLE);
            port_grant  <= grant_next;
            port_tdo    <= ~port_grant | {NUM_PORTS{jtag_tdo}};
            jtag_clk    <= clk_next;
            jtag_tms    <= tms_next;
            jtag_tdi    <= tdi_next;
            jtag_rst_n  <= rst_n_next;
            owner_tck_d <= owner_tck;
            if (state == ST_RESET_SEQ && state_next == ST_OWNED) begin
                active_port  <= pend;
                rr_ptr       <= pend;
                switch_count <= sat_inc16(switch_count);
            end
            // Any TCK activity from the owner keeps it from being timed out.
            if (state != ST_OWNED || owner_tck || owner_tck_d) idle_cnt <= '0;
            else if (idle_cnt != IDLE_MAX)                     idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule
